// File: rtl/rv32i_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | rv32i_ctrl_pkg                                                             |
// | Shared opcode constants and encodings for the RV32I multi-cycle control.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package rv32i_ctrl_pkg;

   localparam logic [6:0] c_op_r      = 7'b0110011;
   localparam logic [6:0] c_op_imm    = 7'b0010011;
   localparam logic [6:0] c_op_load   = 7'b0000011;
   localparam logic [6:0] c_op_store  = 7'b0100011;
   localparam logic [6:0] c_op_branch = 7'b1100011;
   localparam logic [6:0] c_op_jal    = 7'b1101111;
   localparam logic [6:0] c_op_jalr   = 7'b1100111;
   localparam logic [6:0] c_op_lui    = 7'b0110111;
   localparam logic [6:0] c_op_auipc  = 7'b0010111;
   localparam logic [6:0] c_op_system = 7'b1110011;
   localparam logic [6:0] c_op_fence  = 7'b0001111;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      PC_PLUS4 = 2'd0,
      PC_ALU   = 2'd1,
      PC_JALR  = 2'd2
   } pc_sel_t;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MDR = 2'd1,
      WB_PC4 = 2'd2,
      WB_IMM = 2'd3
   } wb_sel_t;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_ILLEGAL = 2'd1,
      CAUSE_TIMEOUT = 2'd2
   } trap_cause_t;

   function automatic logic is_legal_opcode(input logic [6:0] op);
      case (op)
         c_op_r, c_op_imm, c_op_load, c_op_store, c_op_branch, c_op_jal,
         c_op_jalr, c_op_lui, c_op_auipc, c_op_system, c_op_fence: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_mem_watchdog.sv
// +----------------------------------------------------------------------------+
// | rv32i_mem_watchdog                                                         |
// | Counts memory wait cycles; flags timeout when the count hits MEM_TIMEOUT.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rv32i_mem_watchdog #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic count_en_i,
   output logic timeout_o
);

   logic [7:0] count_q;
   logic [7:0] count_d;

   assign timeout_o = (count_q == 8'(MEM_TIMEOUT));

   // Saturates at the limit so a held timeout never wraps back to zero.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = 8'd0;
      end else if (count_en_i && !timeout_o) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rv32i_multicycle_control.sv
// +----------------------------------------------------------------------------+
// | rv32i_multicycle_control                                                   |
// | FETCH/DECODE/EXEC/MEM/WB sequencer with IR, memory handshake and traps.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rv32i_multicycle_control
   import rv32i_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter logic [31:0] RESET_IR    = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ready_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        branch_taken_i,
   output logic [31:0] ir_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic        mem_addr_sel_o,
   output logic        mdr_we_o,
   output logic        alu_a_sel_o,
   output logic        alu_b_sel_o,
   output logic        pc_we_o,
   output logic [1:0]  pc_sel_o,
   output logic        rf_we_o,
   output logic [1:0]  wb_sel_o,
   output logic        retire_o,
   output logic        trap_o,
   output logic [1:0]  trap_cause_o
);

   state_t      state_q, state_d;
   logic [31:0] ir_q, ir_d;
   trap_cause_t cause_q, cause_d;

   logic [6:0]  w_op;
   logic        w_rd_nz;
   logic        w_timeout;
   logic        w_wd_clear;
   logic        w_wd_en;

   assign w_op         = ir_q[6:0];
   assign w_rd_nz      = |ir_q[11:7];
   assign ir_o         = ir_q;
   assign trap_o       = (state_q == S_TRAP);
   assign trap_cause_o = cause_q;

   // Any state change restarts the wait count, which covers entry to FETCH and MEM.
   assign w_wd_clear = (state_d != state_q);
   assign w_wd_en    = mem_req_o && !mem_ready_i;

   rv32i_mem_watchdog #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_watchdog (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (w_wd_clear),
      .count_en_i (w_wd_en),
      .timeout_o  (w_timeout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         ir_q    <= RESET_IR;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cause_q <= cause_d;
      end
   end

   // Outputs are gated by rst so nothing leaks out while reset is held.
   always_comb begin
      state_d        = state_q;
      ir_d           = ir_q;
      cause_d        = cause_q;
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_addr_sel_o = 1'b0;
      mdr_we_o       = 1'b0;
      alu_a_sel_o    = 1'b0;
      alu_b_sel_o    = 1'b0;
      pc_we_o        = 1'b0;
      pc_sel_o       = PC_PLUS4;
      rf_we_o        = 1'b0;
      wb_sel_o       = WB_ALU;
      retire_o       = 1'b0;

      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem_req_o = 1'b1;
               if (mem_ready_i) begin
                  ir_d    = mem_rdata_i;
                  state_d = S_DECODE;
               end else if (w_timeout) begin
                  cause_d = CAUSE_TIMEOUT;
                  state_d = S_TRAP;
               end
            end
            S_DECODE: begin
               if (is_legal_opcode(w_op)) begin
                  state_d = S_EXEC;
               end else begin
                  cause_d = CAUSE_ILLEGAL;
                  state_d = S_TRAP;
               end
            end
            S_EXEC: begin
               case (w_op)
                  c_op_r: state_d = S_WB;
                  c_op_imm, c_op_jalr: begin
                     alu_b_sel_o = 1'b1;
                     state_d     = S_WB;
                  end
                  c_op_load, c_op_store: begin
                     alu_b_sel_o = 1'b1;
                     state_d     = S_MEM;
                  end
                  c_op_branch: begin
                     alu_a_sel_o = 1'b1;
                     alu_b_sel_o = 1'b1;
                     pc_we_o     = 1'b1;
                     pc_sel_o    = branch_taken_i ? PC_ALU : PC_PLUS4;
                     retire_o    = 1'b1;
                     state_d     = S_FETCH;
                  end
                  c_op_jal, c_op_auipc: begin
                     alu_a_sel_o = 1'b1;
                     alu_b_sel_o = 1'b1;
                     state_d     = S_WB;
                  end
                  c_op_system, c_op_fence: begin
                     pc_we_o  = 1'b1;
                     retire_o = 1'b1;
                     state_d  = S_FETCH;
                  end
                  default: state_d = S_WB;
               endcase
            end
            S_MEM: begin
               mem_req_o      = 1'b1;
               mem_addr_sel_o = 1'b1;
               mem_we_o       = (w_op == c_op_store);
               if (mem_ready_i) begin
                  if (w_op == c_op_store) begin
                     pc_we_o  = 1'b1;
                     retire_o = 1'b1;
                     state_d  = S_FETCH;
                  end else begin
                     mdr_we_o = 1'b1;
                     state_d  = S_WB;
                  end
               end else if (w_timeout) begin
                  cause_d = CAUSE_TIMEOUT;
                  state_d = S_TRAP;
               end
            end
            S_WB: begin
               rf_we_o  = w_rd_nz;
               retire_o = 1'b1;
               pc_we_o  = 1'b1;
               case (w_op)
                  c_op_load: wb_sel_o = WB_MDR;
                  c_op_jal: begin
                     wb_sel_o = WB_PC4;
                     pc_sel_o = PC_ALU;
                  end
                  c_op_jalr: begin
                     wb_sel_o = WB_PC4;
                     pc_sel_o = PC_JALR;
                  end
                  c_op_lui: wb_sel_o = WB_IMM;
                  default:  wb_sel_o = WB_ALU;
               endcase
               state_d = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rv32i_multicycle_control.sv
// +----------------------------------------------------------------------------+
// | tb_rv32i_multicycle_control                                                |
// | Scoreboard bench: per-cycle expected strobes queued with their stimulus.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rv32i_multicycle_control;

   localparam logic [31:0] c_reset_ir = 32'h00000013;

   // Packed output layout: req we addr mdr a b pcwe pcsel[2] rf wb[2] ret trap cause[2]
   localparam logic [15:0] c_req       = 16'h8000;
   localparam logic [15:0] c_we        = 16'h4000;
   localparam logic [15:0] c_addr      = 16'h2000;
   localparam logic [15:0] c_mdr       = 16'h1000;
   localparam logic [15:0] c_asel      = 16'h0800;
   localparam logic [15:0] c_bsel      = 16'h0400;
   localparam logic [15:0] c_pcwe      = 16'h0200;
   localparam logic [15:0] c_pcs_jalr  = 16'h0100;
   localparam logic [15:0] c_pcs_alu   = 16'h0080;
   localparam logic [15:0] c_rf        = 16'h0040;
   localparam logic [15:0] c_wb_pc4    = 16'h0020;
   localparam logic [15:0] c_wb_mdr    = 16'h0010;
   localparam logic [15:0] c_wb_imm    = 16'h0030;
   localparam logic [15:0] c_ret       = 16'h0008;
   localparam logic [15:0] c_trap      = 16'h0004;
   localparam logic [15:0] c_cause_to  = 16'h0002;
   localparam logic [15:0] c_cause_ill = 16'h0001;
   localparam logic [15:0] c_none      = 16'h0000;

   logic        clk;
   logic        rst;
   logic        mem_ready_i;
   logic [31:0] mem_rdata_i;
   logic        branch_taken_i;
   logic [31:0] ir_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic        mem_addr_sel_o;
   logic        mdr_we_o;
   logic        alu_a_sel_o;
   logic        alu_b_sel_o;
   logic        pc_we_o;
   logic [1:0]  pc_sel_o;
   logic        rf_we_o;
   logic [1:0]  wb_sel_o;
   logic        retire_o;
   logic        trap_o;
   logic [1:0]  trap_cause_o;

   typedef struct {
      string       tag;
      logic        rdy;
      logic        tkn;
      logic [15:0] exp;
   } step_t;

   step_t sbq[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   rv32i_multicycle_control #(
      .MEM_TIMEOUT (4),
      .RESET_IR    (c_reset_ir)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_ready_i    (mem_ready_i),
      .mem_rdata_i    (mem_rdata_i),
      .branch_taken_i (branch_taken_i),
      .ir_o           (ir_o),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .mem_addr_sel_o (mem_addr_sel_o),
      .mdr_we_o       (mdr_we_o),
      .alu_a_sel_o    (alu_a_sel_o),
      .alu_b_sel_o    (alu_b_sel_o),
      .pc_we_o        (pc_we_o),
      .pc_sel_o       (pc_sel_o),
      .rf_we_o        (rf_we_o),
      .wb_sel_o       (wb_sel_o),
      .retire_o       (retire_o),
      .trap_o         (trap_o),
      .trap_cause_o   (trap_cause_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] outs();
      return {mem_req_o, mem_we_o, mem_addr_sel_o, mdr_we_o, alu_a_sel_o, alu_b_sel_o,
              pc_we_o, pc_sel_o, rf_we_o, wb_sel_o, retire_o, trap_o, trap_cause_o};
   endfunction

   task automatic push(input string tag, input logic rdy, input logic tkn, input logic [15:0] exp);
      step_t s;
      s.tag = tag;
      s.rdy = rdy;
      s.tkn = tkn;
      s.exp = exp;
      sbq.push_back(s);
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      mem_ready_i = 1'b1;
      #1;
      n_tests++;
      if (outs() !== c_none) begin
         n_fail++;
         $display("FAIL reset_outs: got %h expected %h", outs(), c_none);
      end
      n_tests++;
      if (ir_o !== c_reset_ir) begin
         n_fail++;
         $display("FAIL reset_ir: got %h expected %h", ir_o, c_reset_ir);
      end
      @(negedge clk);
      n_tests++;
      if (outs() !== c_none) begin
         n_fail++;
         $display("FAIL reset_held_outs: got %h expected %h", outs(), c_none);
      end
      rst = 1'b0;
   endtask

   task automatic test_alu();
      step_t s;
      mem_rdata_i = 32'h00500093;
      push("addi_F", 1'b1, 1'b0, c_req);
      push("addi_D", 1'b1, 1'b0, c_none);
      push("addi_E", 1'b1, 1'b0, c_bsel);
      push("addi_W", 1'b1, 1'b0, c_rf | c_ret | c_pcwe);
      while (sbq.size() > 0) begin
         s = sbq.pop_front();
         mem_ready_i = s.rdy;
         branch_taken_i = s.tkn;
         #1;
         n_tests++;
         if (outs() !== s.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", s.tag, outs(), s.exp);
         end
         @(negedge clk);
      end
      n_tests++;
      if (ir_o !== 32'h00500093) begin
         n_fail++;
         $display("FAIL addi_ir: got %h expected %h", ir_o, 32'h00500093);
      end
   endtask

   task automatic test_load_wait();
      step_t s;
      mem_rdata_i = 32'h0000A103;
      push("lw_F", 1'b1, 1'b0, c_req);
      push("lw_D", 1'b0, 1'b0, c_none);
      push("lw_E", 1'b0, 1'b0, c_bsel);
      for (int i = 0; i < 3; i++) push("lw_M_wait", 1'b0, 1'b0, c_req | c_addr);
      push("lw_M_hs", 1'b1, 1'b0, c_req | c_addr | c_mdr);
      push("lw_W", 1'b0, 1'b0, c_rf | c_ret | c_pcwe | c_wb_mdr);
      while (sbq.size() > 0) begin
         s = sbq.pop_front();
         mem_ready_i = s.rdy;
         branch_taken_i = s.tkn;
         #1;
         n_tests++;
         if (outs() !== s.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", s.tag, outs(), s.exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      step_t s;
      mem_rdata_i = 32'hFE000EE3;
      push("beq_t_F", 1'b1, 1'b0, c_req);
      push("beq_t_D", 1'b1, 1'b1, c_none);
      push("beq_t_E", 1'b1, 1'b1, c_asel | c_bsel | c_pcwe | c_pcs_alu | c_ret);
      push("beq_n_F", 1'b1, 1'b0, c_req);
      push("beq_n_D", 1'b1, 1'b0, c_none);
      push("beq_n_E", 1'b1, 1'b0, c_asel | c_bsel | c_pcwe | c_ret);
      while (sbq.size() > 0) begin
         s = sbq.pop_front();
         mem_ready_i = s.rdy;
         branch_taken_i = s.tkn;
         #1;
         n_tests++;
         if (outs() !== s.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", s.tag, outs(), s.exp);
         end
         @(negedge clk);
      end
      branch_taken_i = 1'b0;
   endtask

   task automatic test_jal();
      step_t s;
      mem_rdata_i = 32'h0000006F;
      push("jal_F", 1'b1, 1'b0, c_req);
      push("jal_D", 1'b1, 1'b0, c_none);
      push("jal_E", 1'b1, 1'b0, c_asel | c_bsel);
      push("jal_W", 1'b1, 1'b0, c_pcwe | c_pcs_alu | c_wb_pc4 | c_ret);
      while (sbq.size() > 0) begin
         s = sbq.pop_front();
         mem_ready_i = s.rdy;
         branch_taken_i = s.tkn;
         #1;
         n_tests++;
         if (outs() !== s.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", s.tag, outs(), s.exp);
         end
         @(negedge clk);
      end
   endtask

   // Store (with a fetch wait), JALR, LUI and FENCE issued back to back.
   task automatic test_back_to_back();
      step_t s;
      logic [31:0] prog [4];
      int          idx;
      prog[0] = 32'h0020A223;
      prog[1] = 32'h000280E7;
      prog[2] = 32'h123452B7;
      prog[3] = 32'h0000000F;
      push("sw_F_wait", 1'b0, 1'b0, c_req);
      push("sw_F_wait", 1'b0, 1'b0, c_req);
      push("sw_F", 1'b1, 1'b0, c_req);
      push("sw_D", 1'b0, 1'b0, c_none);
      push("sw_E", 1'b0, 1'b0, c_bsel);
      push("sw_M", 1'b1, 1'b0, c_req | c_we | c_addr | c_pcwe | c_ret);
      push("jalr_F", 1'b1, 1'b0, c_req);
      push("jalr_D", 1'b1, 1'b0, c_none);
      push("jalr_E", 1'b1, 1'b0, c_bsel);
      push("jalr_W", 1'b1, 1'b0, c_rf | c_ret | c_pcwe | c_pcs_jalr | c_wb_pc4);
      push("lui_F", 1'b1, 1'b0, c_req);
      push("lui_D", 1'b1, 1'b0, c_none);
      push("lui_E", 1'b1, 1'b0, c_none);
      push("lui_W", 1'b1, 1'b0, c_rf | c_ret | c_pcwe | c_wb_imm);
      push("fence_F", 1'b1, 1'b0, c_req);
      push("fence_D", 1'b1, 1'b0, c_none);
      push("fence_E", 1'b1, 1'b0, c_pcwe | c_ret);
      idx = 0;
      while (sbq.size() > 0) begin
         s = sbq.pop_front();
         mem_ready_i = s.rdy;
         branch_taken_i = s.tkn;
         mem_rdata_i = prog[idx];
         #1;
         n_tests++;
         if (outs() !== s.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", s.tag, outs(), s.exp);
         end
         if (s.exp & c_ret) idx = (idx + 1) % 4;
         @(negedge clk);
      end
      n_tests++;
      if (ir_o !== prog[3]) begin
         n_fail++;
         $display("FAIL b2b_ir: got %h expected %h", ir_o, prog[3]);
      end
   endtask

   task automatic test_illegal();
      step_t s;
      mem_rdata_i = 32'hFFFFFFFF;
      push("ill_F", 1'b1, 1'b0, c_req);
      push("ill_D", 1'b1, 1'b0, c_none);
      for (int i = 0; i < 20; i++) push("ill_TRAP", i[0], 1'b0, c_trap | c_cause_ill);
      while (sbq.size() > 0) begin
         s = sbq.pop_front();
         mem_ready_i = s.rdy;
         branch_taken_i = s.tkn;
         #1;
         n_tests++;
         if (outs() !== s.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", s.tag, outs(), s.exp);
         end
         @(negedge clk);
      end
      n_tests++;
      if (ir_o !== 32'hFFFFFFFF) begin
         n_fail++;
         $display("FAIL ill_ir: got %h expected %h", ir_o, 32'hFFFFFFFF);
      end
   endtask

   task automatic test_timeout();
      step_t s;
      mem_rdata_i = 32'h00500093;
      for (int i = 0; i < 5; i++) push("to_F_wait", 1'b0, 1'b0, c_req);
      for (int i = 0; i < 3; i++) push("to_TRAP", 1'b1, 1'b0, c_trap | c_cause_to);
      while (sbq.size() > 0) begin
         s = sbq.pop_front();
         mem_ready_i = s.rdy;
         branch_taken_i = s.tkn;
         #1;
         n_tests++;
         if (outs() !== s.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", s.tag, outs(), s.exp);
         end
         @(negedge clk);
      end
      n_tests++;
      if (ir_o !== c_reset_ir) begin
         n_fail++;
         $display("FAIL to_ir: got %h expected %h", ir_o, c_reset_ir);
      end
   endtask

   task automatic test_timeout_edge();
      step_t s;
      mem_rdata_i = 32'h00A00113;
      for (int i = 0; i < 4; i++) push("edge_F_wait", 1'b0, 1'b0, c_req);
      push("edge_F_hs", 1'b1, 1'b0, c_req);
      push("edge_D", 1'b0, 1'b0, c_none);
      push("edge_E", 1'b0, 1'b0, c_bsel);
      push("edge_W", 1'b0, 1'b0, c_rf | c_ret | c_pcwe);
      push("edge_F_next", 1'b0, 1'b0, c_req);
      while (sbq.size() > 0) begin
         s = sbq.pop_front();
         mem_ready_i = s.rdy;
         branch_taken_i = s.tkn;
         #1;
         n_tests++;
         if (outs() !== s.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", s.tag, outs(), s.exp);
         end
         @(negedge clk);
      end
      n_tests++;
      if (ir_o !== 32'h00A00113) begin
         n_fail++;
         $display("FAIL edge_ir: got %h expected %h", ir_o, 32'h00A00113);
      end
   endtask

   initial begin
      rst            = 1'b1;
      mem_ready_i    = 1'b0;
      mem_rdata_i    = 32'h0;
      branch_taken_i = 1'b0;
      @(negedge clk);
      test_reset();
      test_alu();
      test_load_wait();
      test_branch();
      test_jal();
      test_back_to_back();
      test_illegal();
      test_reset();
      test_timeout();
      test_reset();
      test_timeout_edge();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rv32i_multicycle_control.md
Name: rv32i_multicycle_control

Overview:
Multi-cycle sequencer for the RV32I core. It owns the instruction register and walks each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the memory request handshake, the datapath mux selects and the write strobes. The latched instruction feeds the immediate generator, register file and ALU decode. A memory-wait watchdog and an illegal-opcode detector put the core into a sticky TRAP state.

Parameters:
MEM_TIMEOUT, 255, max cycles mem_req may wait for mem_ready before trapping (1..255)
RESET_IR, 32'h00000013, IR value at reset (addi x0,x0,0)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
mem_ready  in  1  memory accepts/completes the current request this edge
mem_rdata  in  32  fetch data, captured into ir on FETCH handshake
branch_taken  in  1  comparator result for the current branch, valid in EXEC
ir  out  32  latched instruction
mem_req  out  1  memory request
mem_we  out  1  store request (valid with mem_req)
mem_addr_sel  out  1  0=PC, 1=ALU result
mdr_we  out  1  capture load data into MDR
alu_a_sel  out  1  0=rs1, 1=PC
alu_b_sel  out  1  0=rs2, 1=imm
pc_we  out  1  PC update strobe
pc_sel  out  2  0=PC+4, 1=ALU target, 2=ALU target & ~1 (JALR)
rf_we  out  1  register-file write strobe
wb_sel  out  2  0=ALU, 1=MDR, 2=PC+4, 3=imm (LUI)
retire  out  1  one-cycle pulse when an instruction completes
trap  out  1  sticky; core halted
trap_cause  out  2  0=none, 1=illegal opcode, 2=memory timeout

Behaviour:
- Reset (async): state=FETCH, ir=RESET_IR, wait counter=0, trap=0, trap_cause=0. While rst is high, every strobe, mem_req and retire is 0. The first mem_req is asserted in the first cycle after rst deasserts.
- Handshake: mem_req, mem_we and mem_addr_sel stay stable until mem_ready is sampled high at a rising edge. The transfer completes on that edge. mem_ready is ignored while mem_req=0.
- FETCH: mem_req=1, mem_addr_sel=0. On handshake, ir<=mem_rdata and go to DECODE.
- DECODE: one cycle with no strobes. Check the opcode ir[6:0].
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011, 0001111.
  - Any other opcode sets trap_cause=1 and goes to TRAP.
- EXEC selects by opcode:
  - R: a=rs1, b=rs2.
  - I-ALU, load, store, JALR: a=rs1, b=imm.
  - Branch, JAL, AUIPC: a=PC, b=imm.
- EXEC next state:
  - Branch: pc_we=1, pc_sel = branch_taken ? 1 : 0, retire=1, go to FETCH.
  - SYSTEM/FENCE: treated as NOP. pc_we=1, pc_sel=0, retire=1, go to FETCH.
  - Load/store: go to MEM.
  - All others: go to WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for store.
  - Store handshake: pc_we=1, pc_sel=0, retire=1, go to FETCH.
  - Load handshake: mdr_we=1, go to WB.
- WB: rf_we=1 unless ir[11:7]==0. retire=1.
  - wb_sel: ALU for R/I-ALU/AUIPC, MDR for load, PC+4 for JAL/JALR, imm for LUI.
  - pc_we=1, with pc_sel=1 for JAL, 2 for JALR, else 0.
  - Go to FETCH.
- Per-instruction rule: pc_we and retire each pulse exactly once, in the same cycle.
- Latency with zero-wait memory (mem_ready=1 in the request cycle):
  - branch/NOP 3 cycles; ALU/LUI/AUIPC/JAL/JALR 4; store 4; load 5.
  - Each memory wait cycle adds 1.
- Watchdog:
  - The counter clears on entering FETCH or MEM and increments each cycle mem_req=1 without mem_ready.
  - When the count reaches MEM_TIMEOUT with no handshake, the next edge enters TRAP with trap_cause=2.
  - A handshake on the same edge as the count reaching MEM_TIMEOUT wins: no trap.
- TRAP: trap=1, all strobes 0, mem_req=0. The state is held until rst.
- Reset mid-operation: everything returns to the reset values immediately, including mid-handshake. No partial strobe may follow.

Decomposition:
- Package rv32i_ctrl_pkg holds:
  - opcode localparams;
  - state encoding (FETCH, DECODE, EXEC, MEM, WB, TRAP);
  - pc_sel, wb_sel and trap_cause encodings.
- The immediate generator and other decoders share the opcode constants from this package.
- One sub-module: rv32i_mem_watchdog, containing the counter, clear/enable inputs and a timeout output, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset, then mem_ready=1 and a fetch of 0x00500093 (addi x1,x0,5).
  - ir latched at edge 1.
  - rf_we/retire/pc_we high in cycle 4, with wb_sel=0, pc_sel=0.
- Fetch of 0x0000A103 (lw x2,0(x1)) with mem_ready held low for 3 cycles in MEM.
  - mdr_we on the handshake.
  - WB with wb_sel=1; retire at cycle 8.
- Fetch of beq 0xFE000EE3 with branch_taken=1, then with branch_taken=0.
  - EXEC cycle 3 gives pc_we=1 with pc_sel=1, then with pc_sel=0.
  - No rf_we in either case.
- Fetch of 0x0000006F (jal x0,0).
  - WB gives pc_sel=1 and wb_sel=2, with rf_we=0 because rd=x0.
- Fetch of 0xFFFFFFFF.
  - DECODE goes to TRAP with trap_cause=1.
  - mem_req stays 0 for 20 cycles; rst clears it.
- mem_ready held 0 during FETCH with MEM_TIMEOUT=4.
  - trap_cause=2 after 5 cycles.
  - Repeat with mem_ready=1 exactly at count 4: no trap, ir latched.
